// File: rtl/audio_pkg.sv
// Shared types and default sizing for the codec serial-port block.
//   e_i2s_state     : serial-port FSM state (IDLE, RUN)
//   AUDIO_DW        : default audio sample width per channel
//   AUDIO_SLOT_BITS : default BCLK periods per channel slot
package audio_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } e_i2s_state;

    localparam int AUDIO_DW        = 24;
    localparam int AUDIO_SLOT_BITS = 32;

endpackage

// File: rtl/i2s_codec_if_if.sv
// Bus bundle between the DSP datapath, the serial-port master and the codec pins.
//   slave  : seen by i2s_codec_if (takes DAC pairs and ADCDAT, drives ADC pairs and pins)
//   master : seen by the datapath / bench (drives DAC pairs, i_en and ADCDAT)
// Signals:
//   i_en                      start streaming (codec config done)
//   i_dac_left/right/valid    DAC sample pair offer, o_dac_ready accepts it
//   o_adc_left/right/valid    captured ADC pair, valid is a one-cycle pulse
//   o_underrun                frame started with an empty holding register
//   o_bclk/o_lrck/o_dacdat    codec pins, i_adcdat serial ADC data
interface i2s_codec_if_if
    import audio_pkg::*;
#(
    parameter int DW = AUDIO_DW
);

    logic          i_en;
    logic [DW-1:0] i_dac_left;
    logic [DW-1:0] i_dac_right;
    logic          i_dac_valid;
    logic          o_dac_ready;
    logic [DW-1:0] o_adc_left;
    logic [DW-1:0] o_adc_right;
    logic          o_adc_valid;
    logic          o_underrun;
    logic          o_bclk;
    logic          o_lrck;
    logic          o_dacdat;
    logic          i_adcdat;

    modport master (
        output i_en, i_dac_left, i_dac_right, i_dac_valid, i_adcdat,
        input  o_dac_ready, o_adc_left, o_adc_right, o_adc_valid,
        input  o_underrun, o_bclk, o_lrck, o_dacdat
    );

    modport slave (
        input  i_en, i_dac_left, i_dac_right, i_dac_valid, i_adcdat,
        output o_dac_ready, o_adc_left, o_adc_right, o_adc_valid,
        output o_underrun, o_bclk, o_lrck, o_dacdat
    );

endinterface

// File: rtl/bclk_gen.sv
// Bit-clock generator: divides clk down to BCLK and flags its edges.
//   clk, rst_n : system clock, synchronous active-low reset
//   run        : 1 = divider counting, 0 = divider and bclk held at 0
//   bclk       : registered bit clock
//   rise/fall  : one-cycle strobes, high in the cycle whose closing edge
//                takes bclk 0->1 / 1->0
module bclk_gen #(
    parameter int BCLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam int DCW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DCW-1:0] div_cnt;
    logic           tc;

    assign tc   = (div_cnt == DCW'(BCLK_DIV - 1));
    // Strobes are decoded from the registers so the consumer sees the edge
    // in the same cycle the bclk flop toggles.
    assign rise = run & tc & ~bclk;
    assign fall = run & tc & bclk;

    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + DCW'(1);
        end
    end

endmodule

// File: rtl/i2s_codec_if.sv
// Left-justified, MSB-first audio serial-port master (LRCK high = left).
// Streams DAC pairs out on DACDAT and captures ADCDAT into parallel pairs.
//   i_clk, i_rst_n : system clock, synchronous active-low reset
//   bus            : i2s_codec_if_if.slave bundle (DAC/ADC pairs, i_en, codec pins)
// One frame = 2*SLOT_BITS bit clocks; each channel carries DW bits MSB first,
// the rest of the slot is zero padded on DACDAT and ignored on ADCDAT.
module i2s_codec_if
    import audio_pkg::*;
#(
    parameter int DW        = AUDIO_DW,
    parameter int SLOT_BITS = AUDIO_SLOT_BITS,
    parameter int BCLK_DIV  = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    i2s_codec_if_if.slave bus
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int BCW        = $clog2(FRAME_BITS);
    localparam logic [DW-1:0] MSB_MASK = DW'(1) << (DW - 1);

    e_i2s_state    state;
    logic          run;
    logic          bclk, rise, fall;

    logic [BCW-1:0] bit_cnt;
    logic [BCW-1:0] bit_nxt;
    logic [BCW-1:0] cur_k, nxt_k;
    logic           cur_left, nxt_left;
    logic           wrap, load, wr, capture, nxt_dat;
    logic [DW-1:0]  nxt_word;

    logic [DW-1:0]  dac_l, dac_r;       // frame being transmitted
    logic [DW-1:0]  hold_l, hold_r;     // one-entry holding register
    logic [DW-1:0]  adc_l, adc_r;       // capture shift registers
    logic [DW-1:0]  adc_out_l, adc_out_r;
    logic           ready_q, adc_valid_q, underrun_q, lrck_q, dacdat_q;

    assign run = (state == RUN);

    bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .run   (run),
        .bclk  (bclk),
        .rise  (rise),
        .fall  (fall)
    );

    // Slot decode for the current bit and for the bit that a fall event
    // moves to. The DACDAT bit is picked with a shifted one-hot mask, so
    // any k >= DW falls off the mask and yields the zero pad.
    always_comb begin
        wrap     = (bit_cnt == BCW'(FRAME_BITS - 1));
        bit_nxt  = wrap ? '0 : bit_cnt + BCW'(1);
        cur_left = (bit_cnt < BCW'(SLOT_BITS));
        cur_k    = cur_left ? bit_cnt : bit_cnt - BCW'(SLOT_BITS);
        nxt_left = (bit_nxt < BCW'(SLOT_BITS));
        nxt_k    = nxt_left ? bit_nxt : bit_nxt - BCW'(SLOT_BITS);
        nxt_word = nxt_left ? dac_l : dac_r;
        nxt_dat  = |(nxt_word & (MSB_MASK >> nxt_k));
    end

    // A frame starts on entry to RUN and on every wrap while still enabled.
    // A wrap with i_en low closes the last frame instead of starting one.
    assign load    = ((state == IDLE) && bus.i_en) ||
                     ((state == RUN) && fall && wrap && bus.i_en);
    assign wr      = bus.i_dac_valid && ready_q;
    assign capture = rise && (cur_k < BCW'(DW));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            dac_l       <= '0;
            dac_r       <= '0;
            hold_l      <= '0;
            hold_r      <= '0;
            adc_l       <= '0;
            adc_r       <= '0;
            adc_out_l   <= '0;
            adc_out_r   <= '0;
            ready_q     <= 1'b1;
            adc_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            lrck_q      <= 1'b0;
            dacdat_q    <= 1'b0;
        end else begin
            adc_valid_q <= 1'b0;
            underrun_q  <= 1'b0;

            // ready_q is the empty flag. A write can only land while empty,
            // so it never collides with a consume on the same edge.
            if (wr) begin
                hold_l  <= bus.i_dac_left;
                hold_r  <= bus.i_dac_right;
                ready_q <= 1'b0;
            end else if (load && !ready_q) begin
                ready_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.i_en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (capture) begin
                        if (cur_left) begin
                            adc_l <= (adc_l << 1) | DW'(bus.i_adcdat);
                        end else begin
                            adc_r <= (adc_r << 1) | DW'(bus.i_adcdat);
                        end
                    end
                    if (fall) begin
                        if (wrap) begin
                            adc_out_l   <= adc_l;
                            adc_out_r   <= adc_r;
                            adc_valid_q <= 1'b1;
                            if (!bus.i_en) begin
                                state    <= IDLE;
                                bit_cnt  <= '0;
                                lrck_q   <= 1'b0;
                                dacdat_q <= 1'b0;
                            end
                        end else begin
                            bit_cnt  <= bit_nxt;
                            lrck_q   <= nxt_left;
                            dacdat_q <= nxt_dat;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Frame start: the load sees the holding state from before this
            // edge, so a pair written right now waits for the next frame.
            if (load) begin
                bit_cnt    <= '0;
                lrck_q     <= 1'b1;
                underrun_q <= ready_q;
                if (ready_q) begin
                    dac_l    <= '0;
                    dac_r    <= '0;
                    dacdat_q <= 1'b0;
                end else begin
                    dac_l    <= hold_l;
                    dac_r    <= hold_r;
                    dacdat_q <= hold_l[DW-1];
                end
            end
        end
    end

    assign bus.o_bclk      = bclk;
    assign bus.o_lrck      = lrck_q;
    assign bus.o_dacdat    = dacdat_q;
    assign bus.o_dac_ready = ready_q;
    assign bus.o_adc_left  = adc_out_l;
    assign bus.o_adc_right = adc_out_r;
    assign bus.o_adc_valid = adc_valid_q;
    assign bus.o_underrun  = underrun_q;

endmodule

// File: tb/tb_i2s_codec_if.sv
// Directed bench for i2s_codec_if with DW=24, SLOT_BITS=32, BCLK_DIV=2
// (4 clocks per bit, 256 clocks per frame). n counts clocks since the
// frame-start edge; outputs are sampled 1 time unit after each rising edge.
module tb_i2s_codec_if;

    localparam int DW  = audio_pkg::AUDIO_DW;
    localparam int SB  = audio_pkg::AUDIO_SLOT_BITS;
    localparam int DIV = 2;

    logic clk;
    logic rst_n;
    logic loop_en;
    int   n_cmp;
    int   n_err;

    i2s_codec_if_if #(.DW(DW)) bus ();

    i2s_codec_if #(
        .DW        (DW),
        .SLOT_BITS (SB),
        .BCLK_DIV  (DIV)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    assign bus.i_adcdat = loop_en & bus.o_dacdat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected DACDAT for clock n of a frame carrying pair (l, r).
    function automatic logic exp_dat(input int n, input logic [DW-1:0] l,
                                     input logic [DW-1:0] r);
        int b;
        int k;
        logic [DW-1:0] w;
        b = (n / 4) % (2 * SB);
        k = b % SB;
        w = (b < SB) ? l : r;
        if (k >= DW) return 1'b0;
        return w[5'(DW - 1 - k)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.i_en        = 1'b0;
        bus.i_dac_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_cmp++; if (bus.o_bclk !== 1'b0) begin n_err++; $display("FAIL reset_bclk: got %b want 0", bus.o_bclk); end
        n_cmp++; if (bus.o_lrck !== 1'b0) begin n_err++; $display("FAIL reset_lrck: got %b want 0", bus.o_lrck); end
        n_cmp++; if (bus.o_dacdat !== 1'b0) begin n_err++; $display("FAIL reset_dacdat: got %b want 0", bus.o_dacdat); end
        n_cmp++; if (bus.o_dac_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.o_dac_ready); end
        n_cmp++; if (bus.o_adc_valid !== 1'b0) begin n_err++; $display("FAIL reset_adc_valid: got %b want 0", bus.o_adc_valid); end
        n_cmp++; if (bus.o_underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b want 0", bus.o_underrun); end
        n_cmp++; if (bus.o_adc_left !== 24'h0) begin n_err++; $display("FAIL reset_adc_left: got %h want 0", bus.o_adc_left); end
    endtask

    task automatic test_loopback();
        int   chg;
        int   pulses;
        logic prev;
        do_reset();
        loop_en         = 1'b1;
        bus.i_dac_left  = 24'hA5F00F;
        bus.i_dac_right = 24'h123456;
        bus.i_dac_valid = 1'b1;
        tick();
        bus.i_dac_valid = 1'b0;
        n_cmp++; if (bus.o_dac_ready !== 1'b0) begin n_err++; $display("FAIL loop_ready_after_write: got %b want 0", bus.o_dac_ready); end
        bus.i_en = 1'b1;
        tick();
        n_cmp++; if (bus.o_underrun !== 1'b0) begin n_err++; $display("FAIL loop_entry_underrun: got %b want 0", bus.o_underrun); end
        n_cmp++; if (bus.o_dac_ready !== 1'b1) begin n_err++; $display("FAIL loop_ready_consumed: got %b want 1", bus.o_dac_ready); end
        n_cmp++; if (bus.o_adc_valid !== 1'b0) begin n_err++; $display("FAIL loop_entry_adc_valid: got %b want 0", bus.o_adc_valid); end
        chg    = 0;
        pulses = 0;
        prev   = bus.o_dacdat;
        for (int n = 0; n < 256; n++) begin
            if (n > 0) tick();
            n_cmp++; if (bus.o_bclk !== ((n % 4) >= 2)) begin n_err++; $display("FAIL loop_bclk n=%0d: got %b want %b", n, bus.o_bclk, ((n % 4) >= 2)); end
            n_cmp++; if (bus.o_lrck !== (n < 128)) begin n_err++; $display("FAIL loop_lrck n=%0d: got %b want %b", n, bus.o_lrck, (n < 128)); end
            n_cmp++; if (bus.o_dacdat !== exp_dat(n, 24'hA5F00F, 24'h123456)) begin n_err++; $display("FAIL loop_dacdat n=%0d: got %b want %b", n, bus.o_dacdat, exp_dat(n, 24'hA5F00F, 24'h123456)); end
            if (n > 0 && (n % 4) != 0 && bus.o_dacdat !== prev) chg++;
            prev = bus.o_dacdat;
            if (bus.o_adc_valid === 1'b1) pulses++;
        end
        n_cmp++; if (chg !== 0) begin n_err++; $display("FAIL loop_dacdat_off_fall: got %0d changes want 0", chg); end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL loop_early_valid: got %0d pulses want 0", pulses); end
        tick();
        n_cmp++; if (bus.o_adc_valid !== 1'b1) begin n_err++; $display("FAIL loop_adc_valid: got %b want 1", bus.o_adc_valid); end
        n_cmp++; if (bus.o_adc_left !== 24'hA5F00F) begin n_err++; $display("FAIL loop_adc_left: got %h want a5f00f", bus.o_adc_left); end
        n_cmp++; if (bus.o_adc_right !== 24'h123456) begin n_err++; $display("FAIL loop_adc_right: got %h want 123456", bus.o_adc_right); end
        n_cmp++; if (bus.o_underrun !== 1'b1) begin n_err++; $display("FAIL loop_second_underrun: got %b want 1", bus.o_underrun); end
        n_cmp++; if (bus.o_lrck !== 1'b1) begin n_err++; $display("FAIL loop_lrck_wrap: got %b want 1", bus.o_lrck); end
        tick();
        n_cmp++; if (bus.o_adc_valid !== 1'b0) begin n_err++; $display("FAIL loop_valid_width: got %b want 0", bus.o_adc_valid); end
        loop_en = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        bus.i_dac_left  = 24'h000000;
        bus.i_dac_right = 24'hFFFFFF;
        bus.i_dac_valid = 1'b1;
        tick();
        bus.i_dac_valid = 1'b0;
        bus.i_en        = 1'b1;
        tick();
        bus.i_dac_valid = 1'b1;
        tick();
        bus.i_dac_valid = 1'b0;
        for (int n = 2; n <= 162; n++) tick();
        n_cmp++; if (bus.o_bclk !== 1'b1) begin n_err++; $display("FAIL midrst_pre_bclk: got %b want 1", bus.o_bclk); end
        n_cmp++; if (bus.o_dacdat !== 1'b1) begin n_err++; $display("FAIL midrst_pre_dacdat: got %b want 1", bus.o_dacdat); end
        n_cmp++; if (bus.o_dac_ready !== 1'b0) begin n_err++; $display("FAIL midrst_pre_ready: got %b want 0", bus.o_dac_ready); end
        rst_n    = 1'b0;
        bus.i_en = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if (bus.o_bclk !== 1'b0) begin n_err++; $display("FAIL midrst_bclk: got %b want 0", bus.o_bclk); end
        n_cmp++; if (bus.o_lrck !== 1'b0) begin n_err++; $display("FAIL midrst_lrck: got %b want 0", bus.o_lrck); end
        n_cmp++; if (bus.o_dacdat !== 1'b0) begin n_err++; $display("FAIL midrst_dacdat: got %b want 0", bus.o_dacdat); end
        n_cmp++; if (bus.o_dac_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", bus.o_dac_ready); end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (bus.o_bclk !== 1'b0) begin n_err++; $display("FAIL midrst_idle_bclk c=%0d: got %b want 0", i, bus.o_bclk); end
        end
    endtask

    task automatic test_underrun();
        do_reset();
        bus.i_en = 1'b1;
        tick();
        n_cmp++; if (bus.o_underrun !== 1'b1) begin n_err++; $display("FAIL ur_entry_pulse: got %b want 1", bus.o_underrun); end
        n_cmp++; if (bus.o_lrck !== 1'b1) begin n_err++; $display("FAIL ur_entry_lrck: got %b want 1", bus.o_lrck); end
        for (int n = 0; n < 256; n++) begin
            if (n > 0) begin
                tick();
                n_cmp++; if (bus.o_underrun !== 1'b0) begin n_err++; $display("FAIL ur_pulse_width n=%0d: got %b want 0", n, bus.o_underrun); end
            end
            n_cmp++; if (bus.o_dacdat !== 1'b0) begin n_err++; $display("FAIL ur_dacdat n=%0d: got %b want 0", n, bus.o_dacdat); end
            n_cmp++; if (bus.o_dac_ready !== 1'b1) begin n_err++; $display("FAIL ur_ready n=%0d: got %b want 1", n, bus.o_dac_ready); end
        end
        tick();
        n_cmp++; if (bus.o_underrun !== 1'b1) begin n_err++; $display("FAIL ur_next_frame: got %b want 1", bus.o_underrun); end
    endtask

    task automatic test_boundary_write();
        do_reset();
        bus.i_en = 1'b1;
        tick();
        for (int n = 1; n <= 255; n++) tick();
        bus.i_dac_left  = 24'h800001;
        bus.i_dac_right = 24'h7FFFFF;
        bus.i_dac_valid = 1'b1;
        tick();
        bus.i_dac_valid = 1'b0;
        n_cmp++; if (bus.o_underrun !== 1'b1) begin n_err++; $display("FAIL bw_underrun: got %b want 1", bus.o_underrun); end
        n_cmp++; if (bus.o_dac_ready !== 1'b0) begin n_err++; $display("FAIL bw_ready_held: got %b want 0", bus.o_dac_ready); end
        for (int n = 256; n < 512; n++) begin
            if (n > 256) tick();
            n_cmp++; if (bus.o_dacdat !== 1'b0) begin n_err++; $display("FAIL bw_zero_frame n=%0d: got %b want 0", n, bus.o_dacdat); end
            n_cmp++; if (bus.o_dac_ready !== 1'b0) begin n_err++; $display("FAIL bw_ready n=%0d: got %b want 0", n, bus.o_dac_ready); end
        end
        tick();
        n_cmp++; if (bus.o_underrun !== 1'b0) begin n_err++; $display("FAIL bw_no_underrun: got %b want 0", bus.o_underrun); end
        n_cmp++; if (bus.o_dac_ready !== 1'b1) begin n_err++; $display("FAIL bw_ready_free: got %b want 1", bus.o_dac_ready); end
        for (int n = 512; n < 768; n++) begin
            if (n > 512) tick();
            n_cmp++; if (bus.o_dacdat !== exp_dat(n, 24'h800001, 24'h7FFFFF)) begin n_err++; $display("FAIL bw_dacdat n=%0d: got %b want %b", n, bus.o_dacdat, exp_dat(n, 24'h800001, 24'h7FFFFF)); end
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        loop_en         = 1'b1;
        bus.i_dac_left  = 24'h00FF00;
        bus.i_dac_right = 24'hABCDEF;
        bus.i_dac_valid = 1'b1;
        tick();
        bus.i_dac_valid = 1'b0;
        bus.i_en        = 1'b1;
        tick();
        for (int n = 0; n < 256; n++) begin
            if (n > 0) tick();
            n_cmp++; if (bus.o_bclk !== ((n % 4) >= 2)) begin n_err++; $display("FAIL drop_bclk n=%0d: got %b want %b", n, bus.o_bclk, ((n % 4) >= 2)); end
            n_cmp++; if (bus.o_dacdat !== exp_dat(n, 24'h00FF00, 24'hABCDEF)) begin n_err++; $display("FAIL drop_dacdat n=%0d: got %b want %b", n, bus.o_dacdat, exp_dat(n, 24'h00FF00, 24'hABCDEF)); end
            if (n == 1) begin
                bus.i_dac_left  = 24'h800000;
                bus.i_dac_right = 24'h000001;
                bus.i_dac_valid = 1'b1;
            end
            if (n == 2) bus.i_dac_valid = 1'b0;
            if (n == 40) bus.i_en = 1'b0;
        end
        tick();
        n_cmp++; if (bus.o_adc_valid !== 1'b1) begin n_err++; $display("FAIL drop_adc_valid: got %b want 1", bus.o_adc_valid); end
        n_cmp++; if (bus.o_adc_left !== 24'h00FF00) begin n_err++; $display("FAIL drop_adc_left: got %h want 00ff00", bus.o_adc_left); end
        n_cmp++; if (bus.o_adc_right !== 24'hABCDEF) begin n_err++; $display("FAIL drop_adc_right: got %h want abcdef", bus.o_adc_right); end
        n_cmp++; if (bus.o_underrun !== 1'b0) begin n_err++; $display("FAIL drop_exit_underrun: got %b want 0", bus.o_underrun); end
        n_cmp++; if (bus.o_dac_ready !== 1'b0) begin n_err++; $display("FAIL drop_hold_kept: got %b want 0", bus.o_dac_ready); end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            n_cmp++; if (bus.o_bclk !== 1'b0) begin n_err++; $display("FAIL drop_idle_bclk c=%0d: got %b want 0", i, bus.o_bclk); end
            n_cmp++; if (bus.o_lrck !== 1'b0) begin n_err++; $display("FAIL drop_idle_lrck c=%0d: got %b want 0", i, bus.o_lrck); end
            n_cmp++; if (bus.o_dacdat !== 1'b0) begin n_err++; $display("FAIL drop_idle_dacdat c=%0d: got %b want 0", i, bus.o_dacdat); end
        end
        bus.i_en = 1'b1;
        tick();
        n_cmp++; if (bus.o_underrun !== 1'b0) begin n_err++; $display("FAIL drop_restart_underrun: got %b want 0", bus.o_underrun); end
        n_cmp++; if (bus.o_dacdat !== 1'b1) begin n_err++; $display("FAIL drop_restart_msb: got %b want 1", bus.o_dacdat); end
        n_cmp++; if (bus.o_adc_valid !== 1'b0) begin n_err++; $display("FAIL drop_restart_valid: got %b want 0", bus.o_adc_valid); end
        n_cmp++; if (bus.o_dac_ready !== 1'b1) begin n_err++; $display("FAIL drop_restart_ready: got %b want 1", bus.o_dac_ready); end
        bus.i_en = 1'b0;
        loop_en  = 1'b0;
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        loop_en         = 1'b0;
        rst_n           = 1'b0;
        bus.i_en        = 1'b0;
        bus.i_dac_valid = 1'b0;
        bus.i_dac_left  = '0;
        bus.i_dac_right = '0;
        test_reset();
        test_loopback();
        test_reset_mid_frame();
        test_underrun();
        test_boundary_write();
        test_enable_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
